// File: rtl/updn_mod_counter.sv
// updn_mod_counter: up/down modulo counter with programmable modulus and step.
//
// Terminal behaviours selected by mode: 00/11 wrap, 01 saturate, 10 one-shot.
// tc strobes on each overflow/underflow step. done latches on the one-shot clip.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   step enable
//   load     in   synchronous load of data_in (priority over en)
//   data_in  in   load value, clamped to MAX_VAL
//   up       in   1 = count up by INCR, 0 = count down by INCR
//   mode     in   terminal behaviour select
//   out      out  current count (registered)
//   tc       out  terminal-count strobe (registered)
//   done     out  one-shot finished flag (registered)
//
// Optional feature macro: UPDN_MOD_COUNTER_PRESCALE_EN
//   When defined, adds parameter PRESCALE. A step then happens only on every
//   PRESCALE-th qualified en cycle.
module updn_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned INCR    = 1,
  parameter int unsigned MAX_VAL = 2**WIDTH-1
`ifdef UPDN_MOD_COUNTER_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done
);

  // All arithmetic is done one bit wider so overflow is visible.
  localparam logic [WIDTH:0] LP_MAX     = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] LP_INCR    = (WIDTH+1)'(INCR);
  localparam logic [WIDTH:0] LP_MOD     = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH:0] LP_WRAP_DN = (WIDTH+1)'(MAX_VAL + 1 - INCR);

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_done;

  logic [WIDTH:0]   w_ext;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic             w_unf;
  logic             w_clip;
  logic             w_wrap;
  logic             w_oneshot;
  logic             w_en_q;
  logic             w_step;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;

  assign w_ext     = {1'b0, r_out};
  assign w_sum     = w_ext + LP_INCR;
  assign w_ovf     = w_sum > LP_MAX;
  assign w_unf     = w_ext < LP_INCR;
  assign w_clip    = up ? w_ovf : w_unf;
  assign w_oneshot = (mode == 2'b10);
  assign w_wrap    = (mode == 2'b00) || (mode == 2'b11);
  // A latched one-shot ignores en entirely.
  assign w_en_q    = en && !r_done;

  assign w_load_val = ({1'b0, data_in} > LP_MAX) ? WIDTH'(LP_MAX) : data_in;

`ifdef UPDN_MOD_COUNTER_PRESCALE_EN
  localparam int unsigned            LP_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [LP_PW-1:0]       LP_PRE_LAST = LP_PW'(PRESCALE - 1);

  logic [LP_PW-1:0] r_pre;
  logic             w_pre_last;

  assign w_pre_last = (r_pre == LP_PRE_LAST);
  assign w_step     = w_en_q && w_pre_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (load) begin
      r_pre <= '0;
    end else if (w_en_q) begin
      r_pre <= w_pre_last ? '0 : LP_PW'(r_pre + 1'b1);
    end
  end
`else
  assign w_step = w_en_q;
`endif

  always_comb begin
    w_next = r_out;
    if (up) begin
      if (w_ovf) begin
        w_next = w_wrap ? WIDTH'(w_sum - LP_MOD) : WIDTH'(LP_MAX);
      end else begin
        w_next = WIDTH'(w_sum);
      end
    end else begin
      if (w_unf) begin
        w_next = w_wrap ? WIDTH'(w_ext + LP_WRAP_DN) : '0;
      end else begin
        w_next = WIDTH'(w_ext - LP_INCR);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_tc   <= 1'b0;
      r_done <= 1'b0;
    end else if (load) begin
      r_out  <= w_load_val;
      r_tc   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tc <= w_step && w_clip;
      if (w_step) begin
        r_out <= w_next;
        if (w_clip && w_oneshot) begin
          r_done <= 1'b1;
        end
      end
      // Leaving one-shot mode releases the latch; w_step is 0 while done is set.
      if (r_done && !w_oneshot) begin
        r_done <= 1'b0;
      end
    end
  end

  assign out  = r_out;
  assign tc   = r_tc;
  assign done = r_done;

endmodule

// File: tb/tb_updn_mod_counter.sv
// Scoreboard bench for updn_mod_counter (WIDTH=4, INCR=2, MAX_VAL=9).
// The driver pushes expected values as it drives each edge. The monitor pops
// and compares just after that edge.
module tb_updn_mod_counter;

  typedef struct {
    string      name;
    bit         pre;
    logic [3:0] out;
    logic       tc;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] data_in = '0;
  logic       up = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [3:0] out;
  logic       tc;
  logic       done;

  always #5 clk = ~clk;

  updn_mod_counter #(
    .WIDTH   (4),
    .INCR    (2),
    .MAX_VAL (9)
`ifdef UPDN_MOD_COUNTER_PRESCALE_EN
    ,
    .PRESCALE(1)
`endif
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .data_in (data_in),
    .up      (up),
    .mode    (mode),
    .out     (out),
    .tc      (tc),
    .done    (done)
  );

  logic       p_en = 1'b0;
  logic       p_load = 1'b0;
  logic [3:0] p_din = '0;
  logic       p_up = 1'b1;
  logic [1:0] p_mode = 2'b00;
  logic [3:0] p_out;
  logic       p_tc;
  logic       p_done;

`ifdef UPDN_MOD_COUNTER_PRESCALE_EN
  updn_mod_counter #(
    .WIDTH   (4),
    .INCR    (1),
    .MAX_VAL (15),
    .PRESCALE(4)
  ) u_pre (
    .clk     (clk),
    .rst     (rst),
    .en      (p_en),
    .load    (p_load),
    .data_in (p_din),
    .up      (p_up),
    .mode    (p_mode),
    .out     (p_out),
    .tc      (p_tc),
    .done    (p_done)
  );
`else
  assign p_out  = '0;
  assign p_tc   = 1'b0;
  assign p_done = 1'b0;
`endif

  task automatic cmp(input string name, input logic [3:0] a_out, input logic a_tc,
                     input logic a_done, input logic [3:0] e_out, input logic e_tc,
                     input logic e_done);
    n_vec++;
    if (a_out !== e_out || a_tc !== e_tc || a_done !== e_done) begin
      n_err++;
      $display("FAIL %s: got out=%0d tc=%0d done=%0d, want out=%0d tc=%0d done=%0d",
               name, a_out, a_tc, a_done, e_out, e_tc, e_done);
    end
  endtask

  // Monitor: one expected entry is consumed per edge following its push.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.pre) cmp(e.name, p_out, p_tc, p_done, e.out, e.tc, e.done);
      else       cmp(e.name, out, tc, done, e.out, e.tc, e.done);
    end
  end

  task automatic step(input string name, input logic i_en, input logic i_load,
                      input logic [3:0] i_din, input logic i_up, input logic [1:0] i_mode,
                      input logic [3:0] e_out, input logic e_tc, input logic e_done);
    exp_t e;
    @(negedge clk);
    en = i_en; load = i_load; data_in = i_din; up = i_up; mode = i_mode;
    e.name = name; e.pre = 1'b0; e.out = e_out; e.tc = e_tc; e.done = e_done;
    q.push_back(e);
  endtask

  task automatic pstep(input string name, input logic i_en, input logic i_load,
                       input logic [3:0] i_din, input logic [3:0] e_out);
    exp_t e;
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    p_en = i_en; p_load = i_load; p_din = i_din; p_up = 1'b1; p_mode = 2'b00;
    e.name = name; e.pre = 1'b1; e.out = e_out; e.tc = 1'b0; e.done = 1'b0;
    q.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 5) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d entries pending, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    // Reset held for 10 cycles with en active: state must stay cleared.
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    cmp("reset_hold", out, tc, done, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // Wrap up
    step("wrap_up_load", 0, 1, 4'd6, 1, 2'b00, 4'd6, 0, 0);
    step("wrap_up_1",    1, 0, 4'd0, 1, 2'b00, 4'd8, 0, 0);
    step("wrap_up_2",    1, 0, 4'd0, 1, 2'b00, 4'd0, 1, 0);
    step("wrap_up_3",    1, 0, 4'd0, 1, 2'b00, 4'd2, 0, 0);
    step("hold",         0, 0, 4'd0, 1, 2'b00, 4'd2, 0, 0);
    // Wrap down
    step("wrap_dn_load", 0, 1, 4'd1, 0, 2'b00, 4'd1, 0, 0);
    step("wrap_dn_1",    1, 0, 4'd0, 0, 2'b00, 4'd9, 1, 0);
    // Saturate down, repeated clipping keeps tc high
    step("sat_dn_load",  0, 1, 4'd3, 0, 2'b01, 4'd3, 0, 0);
    step("sat_dn_1",     1, 0, 4'd0, 0, 2'b01, 4'd1, 0, 0);
    step("sat_dn_2",     1, 0, 4'd0, 0, 2'b01, 4'd0, 1, 0);
    step("sat_dn_3",     1, 0, 4'd0, 0, 2'b01, 4'd0, 1, 0);
    // Saturate up; exact arrival at MAX_VAL is not terminal
    step("sat_up_load",  0, 1, 4'd7, 1, 2'b01, 4'd7, 0, 0);
    step("sat_up_exact", 1, 0, 4'd0, 1, 2'b01, 4'd9, 0, 0);
    step("sat_up_clip",  1, 0, 4'd0, 1, 2'b01, 4'd9, 1, 0);
    // One-shot
    step("os_load",      0, 1, 4'd5, 1, 2'b10, 4'd5, 0, 0);
    step("os_1",         1, 0, 4'd0, 1, 2'b10, 4'd7, 0, 0);
    step("os_2",         1, 0, 4'd0, 1, 2'b10, 4'd9, 0, 0);
    step("os_3",         1, 0, 4'd0, 1, 2'b10, 4'd9, 1, 1);
    step("os_4",         1, 0, 4'd0, 1, 2'b10, 4'd9, 0, 1);
    step("os_5",         1, 0, 4'd0, 1, 2'b10, 4'd9, 0, 1);
    step("os_reload",    0, 1, 4'd0, 1, 2'b10, 4'd0, 0, 0);
    // One-shot released by a mode change: no step on the releasing edge
    step("os_m_load",    0, 1, 4'd8, 1, 2'b10, 4'd8, 0, 0);
    step("os_m_clip",    1, 0, 4'd0, 1, 2'b10, 4'd9, 1, 1);
    step("os_m_release", 1, 0, 4'd0, 1, 2'b00, 4'd9, 0, 0);
    step("os_m_wrap",    1, 0, 4'd0, 1, 2'b00, 4'd1, 1, 0);
    // Direction change mid-count does not disturb out
    step("dir_change",   1, 0, 4'd0, 0, 2'b00, 4'd9, 1, 0);
    // Load clamp and priority over en
    step("load_clamp",   1, 1, 4'd15, 1, 2'b00, 4'd9, 0, 0);
    drain();

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    cmp("async_rst", out, tc, done, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b1; load = 1'b0;
    @(posedge clk);
    #1;
    cmp("rst_held_en", out, tc, done, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

`ifdef UPDN_MOD_COUNTER_PRESCALE_EN
    pstep("pre_load", 0, 1, 4'd0, 4'd0);
    pstep("pre_1", 1, 0, 4'd0, 4'd0);
    pstep("pre_2", 1, 0, 4'd0, 4'd0);
    pstep("pre_3", 1, 0, 4'd0, 4'd0);
    pstep("pre_4", 1, 0, 4'd0, 4'd1);
    pstep("pre_5", 1, 0, 4'd0, 4'd1);
    pstep("pre_6", 1, 0, 4'd0, 4'd1);
    pstep("pre_7", 1, 0, 4'd0, 4'd1);
    pstep("pre_8", 1, 0, 4'd0, 4'd2);
    pstep("pre_9", 1, 0, 4'd0, 4'd2);
    pstep("pre_10", 1, 0, 4'd0, 4'd2);
    pstep("pre_reload", 0, 1, 4'd5, 4'd5);
    pstep("pre_r1", 1, 0, 4'd0, 4'd5);
    pstep("pre_r2", 1, 0, 4'd0, 4'd5);
    pstep("pre_r3", 1, 0, 4'd0, 4'd5);
    pstep("pre_r4", 1, 0, 4'd0, 4'd6);
    @(negedge clk);
    p_en = 1'b0;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/updn_mod_counter.md
Name: updn_mod_counter

Overview:
- Parametrised successor to the basic load/increment counter.
- Adds up/down direction, a programmable modulus (MAX_VAL) and a configurable step (INCR).
- Supports three terminal behaviours (wrap, saturate, one-shot), plus terminal-count and done flags.
- Used as a general timer/sequencer primitive; shares the single system clock and reset.

Parameters:
- WIDTH, 4, counter/data width in bits.
- INCR, 1, step size per enabled cycle; legal range 1..MAX_VAL.
- MAX_VAL, 2**WIDTH-1, upper bound of count range [0, MAX_VAL]; legal range 1..2**WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  step enable; count advances one step per cycle while high.
- load  in  1  synchronous load of data_in; has priority over en.
- data_in  in  WIDTH  load value.
- up  in  1  direction: 1 = add INCR, 0 = subtract INCR.
- mode  in  2  terminal behaviour: 00 wrap, 01 saturate, 10 one-shot, 11 same as wrap.
- out  out  WIDTH  current count (registered).
- tc  out  1  terminal-count strobe (registered).
- done  out  1  one-shot finished flag (registered).

Behaviour:
- Reset: rst high asynchronously forces out=0, tc=0, done=0, independent of clk; state is held while rst is high.
- Operation priority per rising edge: rst > load > en step > hold.
- Load:
  - out <= min(data_in, MAX_VAL); values above MAX_VAL are clamped.
  - tc <= 0, done <= 0.
- Step (en=1, load=0, done=0), arithmetic in WIDTH+1 bits, no silent truncation:
  - up, overflow when out+INCR > MAX_VAL:
    - wrap: out <= out+INCR-(MAX_VAL+1)
    - saturate and one-shot: out <= MAX_VAL
  - down, underflow when out < INCR:
    - wrap: out <= out+(MAX_VAL+1)-INCR
    - saturate and one-shot: out <= 0
  - otherwise out <= out±INCR.
- tc:
  - 1 for exactly the cycle in which the overflow/underflow step result is presented on out, in all modes.
  - This includes repeated clipping while already saturated with en held.
  - 0 on every other cycle.
- One-shot:
  - On the clipping step, done <= 1 in the same edge as tc.
  - While done=1, en is ignored: out holds and tc stays 0.
  - done clears only on load, rst, or mode changing to a value other than 10 (cleared on the next edge).
- Reaching MAX_VAL or 0 exactly without exceeding it is not a terminal event: tc=0.
- en=0, load=0: all registers hold; tc <= 0.
- up and mode are sampled every edge; a change takes effect on the next step without disturbing out.
- Latency: one cycle from load/en to the updated out/tc/done.

Optional Feature:
- Macro: UPDN_MOD_COUNTER_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE (default 4, minimum 1) and an internal prescaler counter, range 0..PRESCALE-1.
  - The prescaler advances on each en=1 cycle (load=0, done=0).
  - A step (as above) occurs only on the en cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - rst and load clear the prescaler to 0.
  - tc is qualified with the actual step.
- Undefined:
  - No prescaler logic and no PRESCALE parameter.
  - Every qualified en cycle steps.

Test Plan:
- Reset (WIDTH=4, INCR=2, MAX_VAL=9): hold rst 10 cycles, then deassert; also assert rst mid-edge-period -> out=0, tc=0, done=0 immediately, without waiting for clk.
- Wrap up: mode=00, up=1, load 6, then en for 3 cycles -> out 8, 0, 2; tc=1 only on the cycle out=0.
- Wrap and saturate down:
  - mode=00, up=0, load 1, en 1 cycle -> out=9, tc=1.
  - mode=01, load 3, en 3 cycles -> out 1, 0, 0; tc=0, 1, 1.
- One-shot: mode=10, up=1, load 5, en 5 cycles -> out 7, 9, 9, 9, 9; tc=1 only on the 3rd step; done=1 from the 3rd step onward; then load 0 -> done=0, out=0.
- Load clamp and priority: data_in=15 with load=1 and en=1 simultaneously -> out=9 (clamped, no step), tc=0.
- Prescaler (macro defined, PRESCALE=4): mode=00, up=1, INCR=1, load 0, en high for 8 cycles -> out 0, 0, 0, 1, 1, 1, 1, 2; load mid-sequence restarts the prescale phase.
